// File: rtl/veri_bellegi_denetleyici_pkg.sv
// Purpose : shared access-size encodings and controller state type for the data-store controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package veri_bellegi_denetleyici_pkg;

    localparam logic [1:0] BOYUT_BAYT     = 2'b00;
    localparam logic [1:0] BOYUT_YARIM    = 2'b01;
    localparam logic [1:0] BOYUT_KELIME   = 2'b10;
    localparam logic [1:0] BOYUT_GECERSIZ = 2'b11;

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        BEKLE = 2'd1,
        YANIT = 2'd2
    } durum_t;

endpackage

// File: rtl/veri_bellegi_denetleyici_yukleme_hizalayici.sv
// Purpose : picks the addressed byte/halfword/word out of a stored word and extends it to 32 bits.
// Latency : combinational.
// Backpressure: none.
// Ports   : kelime_i stored word, bayt_adres_i byte offset, boyut_i access size,
//           isaretsiz_i zero-extend when 1, veri_o aligned and extended result (0 for illegal size).
module yukleme_hizalayici
    import veri_bellegi_denetleyici_pkg::*;
(
    input  logic [31:0] kelime_i,
    input  logic [1:0]  bayt_adres_i,
    input  logic [1:0]  boyut_i,
    input  logic        isaretsiz_i,
    output logic [31:0] veri_o
);

    logic [7:0]  bayt;
    logic [15:0] yarim;

    always_comb begin
        bayt = 8'h00;
        case (bayt_adres_i)
            2'd0:    bayt = kelime_i[7:0];
            2'd1:    bayt = kelime_i[15:8];
            2'd2:    bayt = kelime_i[23:16];
            default: bayt = kelime_i[31:24];
        endcase

        // Halfwords are always 2-byte aligned, so only bit 1 picks the lane pair.
        yarim = bayt_adres_i[1] ? kelime_i[31:16] : kelime_i[15:0];

        veri_o = 32'h0000_0000;
        case (boyut_i)
            BOYUT_BAYT:   veri_o = {{24{~isaretsiz_i & bayt[7]}}, bayt};
            BOYUT_YARIM:  veri_o = {{16{~isaretsiz_i & yarim[15]}}, yarim};
            BOYUT_KELIME: veri_o = kelime_i;
            default:      veri_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/veri_bellegi_denetleyici.sv
// Purpose : single-port byte-addressable data store with a fixed-latency request/response handshake.
// Latency : response pulse GECIKME cycles after the accepting edge; array access happens on that edge.
// Backpressure: istek_hazir only in idle; one request in flight; responses cannot be stalled.
// Ports   : clk, rst (async active-low); istek_gecerli/istek_hazir request handshake;
//           oku_aktif/yaz_aktif/adres/yaz_veri/boyut/isaretsiz request fields;
//           oku_veri/yanit_gecerli/hata response (oku_veri and hata hold between responses).
module veri_bellegi_denetleyici
    import veri_bellegi_denetleyici_pkg::*;
#(
    parameter int DERINLIK = 1024,
    parameter int GECIKME  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        istek_gecerli,
    output logic        istek_hazir,
    input  logic        oku_aktif,
    input  logic        yaz_aktif,
    input  logic [31:0] adres,
    input  logic [31:0] yaz_veri,
    input  logic [1:0]  boyut,
    input  logic        isaretsiz,
    output logic [31:0] oku_veri,
    output logic        yanit_gecerli,
    output logic        hata
);

    localparam int          ADRES_W         = $clog2(DERINLIK);
    localparam logic [31:0] DERINLIK_SINIR  = 32'(DERINLIK);
    localparam logic [2:0]  SAYAC_BASLANGIC = 3'(GECIKME - 1);

    durum_t      durum_q, durum_d;
    logic [2:0]  sayac_q, sayac_d;
    logic        kabul;

    // Request captured at acceptance; only what the delayed response still needs.
    logic [31:0] kelime_q;
    logic [1:0]  bayt_adres_q;
    logic [1:0]  boyut_q;
    logic        isaretsiz_q;
    logic        oku_q;
    logic        istek_hata_q;

    logic [31:0] oku_veri_q;
    logic        hata_q;

    logic [31:0] bellek_q [DERINLIK];

    logic [ADRES_W-1:0] kelime_idx;
    logic               istek_hata;
    logic [3:0]         yaz_serit;
    logic [31:0]        yaz_kelime;

    logic [31:0] kay_kelime;
    logic [1:0]  kay_bayt_adres;
    logic [1:0]  kay_boyut;
    logic        kay_isaretsiz;
    logic        kay_oku;
    logic        kay_hata;
    logic [31:0] hizali_veri;
    logic        yanit_baslat;

    assign kelime_idx = adres[ADRES_W+1:2];

    // Ready is held low for as long as reset is asserted, not just until the first clock.
    assign istek_hazir   = (durum_q == BOS) && rst;
    assign kabul         = istek_gecerli && istek_hazir;
    assign yanit_gecerli = (durum_q == YANIT);
    assign oku_veri      = oku_veri_q;
    assign hata          = hata_q;

    always_comb begin
        istek_hata = 1'b0;
        if (oku_aktif == yaz_aktif) begin
            istek_hata = 1'b1;
        end
        case (boyut)
            BOYUT_BAYT:   ;
            BOYUT_YARIM:  if (adres[0])            istek_hata = 1'b1;
            BOYUT_KELIME: if (adres[1:0] != 2'b00) istek_hata = 1'b1;
            default:      istek_hata = 1'b1;
        endcase
        if ({2'b00, adres[31:2]} >= DERINLIK_SINIR) begin
            istek_hata = 1'b1;
        end
    end

    // Store data is replicated across lanes so each enabled lane just takes its own slice.
    always_comb begin
        yaz_serit  = 4'b0000;
        yaz_kelime = yaz_veri;
        case (boyut)
            BOYUT_BAYT: begin
                yaz_serit  = 4'b0001 << adres[1:0];
                yaz_kelime = {4{yaz_veri[7:0]}};
            end
            BOYUT_YARIM: begin
                yaz_serit  = adres[1] ? 4'b1100 : 4'b0011;
                yaz_kelime = {2{yaz_veri[15:0]}};
            end
            BOYUT_KELIME: yaz_serit = 4'b1111;
            default:      yaz_serit = 4'b0000;
        endcase
        if (!(kabul && yaz_aktif && !istek_hata)) begin
            yaz_serit = 4'b0000;
        end
    end

    // Contents survive reset by design, so the array has no reset branch.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (yaz_serit[s]) begin
                bellek_q[kelime_idx][8*s +: 8] <= yaz_kelime[8*s +: 8];
            end
        end
    end

    always_comb begin
        durum_d = durum_q;
        sayac_d = sayac_q;
        case (durum_q)
            BOS: begin
                if (kabul) begin
                    if (GECIKME == 1) begin
                        durum_d = YANIT;
                    end else begin
                        durum_d = BEKLE;
                        sayac_d = SAYAC_BASLANGIC;
                    end
                end
            end
            BEKLE: begin
                if (sayac_q <= 3'd1) begin
                    durum_d = YANIT;
                    sayac_d = 3'd0;
                end else begin
                    sayac_d = sayac_q - 3'd1;
                end
            end
            YANIT:   durum_d = BOS;
            default: durum_d = BOS;
        endcase
    end

    // With GECIKME=1 the response is formed on the accepting edge itself, so the
    // live request is used instead of the not-yet-captured copy.
    always_comb begin
        if (kabul) begin
            kay_kelime     = bellek_q[kelime_idx];
            kay_bayt_adres = adres[1:0];
            kay_boyut      = boyut;
            kay_isaretsiz  = isaretsiz;
            kay_oku        = oku_aktif;
            kay_hata       = istek_hata;
        end else begin
            kay_kelime     = kelime_q;
            kay_bayt_adres = bayt_adres_q;
            kay_boyut      = boyut_q;
            kay_isaretsiz  = isaretsiz_q;
            kay_oku        = oku_q;
            kay_hata       = istek_hata_q;
        end
    end

    yukleme_hizalayici u_hizalayici (
        .kelime_i     (kay_kelime),
        .bayt_adres_i (kay_bayt_adres),
        .boyut_i      (kay_boyut),
        .isaretsiz_i  (kay_isaretsiz),
        .veri_o       (hizali_veri)
    );

    assign yanit_baslat = (durum_d == YANIT) && (durum_q != YANIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            durum_q      <= BOS;
            sayac_q      <= 3'd0;
            kelime_q     <= 32'h0000_0000;
            bayt_adres_q <= 2'b00;
            boyut_q      <= BOYUT_BAYT;
            isaretsiz_q  <= 1'b0;
            oku_q        <= 1'b0;
            istek_hata_q <= 1'b0;
            oku_veri_q   <= 32'h0000_0000;
            hata_q       <= 1'b0;
        end else begin
            durum_q <= durum_d;
            sayac_q <= sayac_d;
            if (kabul) begin
                kelime_q     <= bellek_q[kelime_idx];
                bayt_adres_q <= adres[1:0];
                boyut_q      <= boyut;
                isaretsiz_q  <= isaretsiz;
                oku_q        <= oku_aktif;
                istek_hata_q <= istek_hata;
            end
            if (yanit_baslat) begin
                oku_veri_q <= (kay_oku && !kay_hata) ? hizali_veri : 32'h0000_0000;
                hata_q     <= kay_hata;
            end
        end
    end

endmodule
